// File: rtl/cmp_arb.sv
// Two-requester round-robin front end sharing one registered W-bit unsigned
// magnitude comparator; a compare walks IDLE -> CMP -> RESP, one at a time.
module cmp_arb #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_lt_b,
  output logic         res_id,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           last_grant;
  logic           grant;
  logic           win_c;
  logic           latch_c;
  logic           done_c;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;

  // Next-state and arbitration decode
  always_comb begin
    state_next = state;
    latch_c    = 1'b0;
    done_c     = 1'b0;
    // On a tie the requester that was not served last wins
    win_c      = (req0 && req1) ? ~last_grant : req1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = CMP;
          latch_c    = 1'b1;
        end
      end
      CMP: begin
        state_next = RESP;
        done_c     = 1'b1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand capture, result registers and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      a_gt_b     <= 1'b0;
      a_eq_b     <= 1'b0;
      a_lt_b     <= 1'b0;
      res_id     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      busy <= (state_next != IDLE);
      if (latch_c) begin
        op_a  <= win_c ? a1 : a0;
        op_b  <= win_c ? b1 : b0;
        grant <= win_c;
      end
      if (done_c) begin
        a_gt_b <= (op_a > op_b);
        a_eq_b <= (op_a == op_b);
        a_lt_b <= (op_a < op_b);
        res_id <= grant;
        ack0   <= ~grant;
        ack1   <= grant;
      end
      if (state == RESP) last_grant <= grant;
    end
  end

endmodule
